// File: rtl/uart_pkg.sv
// Definitions shared by the UART transmit path: FSM state encodings and
// the frame-width helper shared with uart_controller.
package uart_pkg;

    localparam logic [1:0] ST_IDLE      = 2'b00;
    localparam logic [1:0] ST_ISSUE     = 2'b01;
    localparam logic [1:0] ST_WAIT_DONE = 2'b10;

    function automatic int frame_width(input int byte_width);
        return 8 * byte_width;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: the first set bit of req_mask
// at or above ptr (wrapping modulo NUM_REQ) wins.
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0] req_mask,
    input  logic [2:0]         ptr,
    output logic [2:0]         winner,
    output logic               any
);

    logic [NUM_REQ-1:0] rot_s;
    logic [3:0]         off_s;
    logic [3:0]         sum_s;

    // Rotating the doubled mask puts the requester at ptr in bit 0.
    assign rot_s = NUM_REQ'({req_mask, req_mask} >> ptr);

    // Lowest set bit of the rotated mask; scanning downward lets the lowest hit overwrite.
    always_comb begin
        off_s = 4'd0;
        for (int j = NUM_REQ - 1; j >= 0; j--) begin
            off_s = rot_s[j] ? 4'(j) : off_s;
        end
    end

    assign sum_s  = {1'b0, ptr} + off_s;
    assign winner = (sum_s >= 4'(NUM_REQ)) ? 3'(sum_s - 4'(NUM_REQ)) : sum_s[2:0];
    assign any    = |req_mask;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing the uart_controller transmit handshake among
// NUM_REQ frame producers; all outputs come straight from registers.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ            = 4,
    parameter  int TX_DATA_BYTE_WIDTH = 18,
    localparam int FW                 = frame_width(TX_DATA_BYTE_WIDTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_REQ-1:0]    req_en,
    input  logic [NUM_REQ-1:0]    req_vld,
    input  logic [NUM_REQ*FW-1:0] req_data,
    output logic [NUM_REQ-1:0]    req_ack,
    output logic [NUM_REQ-1:0]    req_done,
    output logic [FW-1:0]         ctl_tx_data,
    output logic                  ctl_tx_vld,
    input  logic                  ctl_tx_rdy,
    output logic                  busy,
    output logic [2:0]            grant_id,
    output logic [15:0]           frame_cnt
);

    localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ - 1){1'b0}}, 1'b1};

    logic [1:0]         state_r;
    logic [2:0]         ptr_r;
    logic [NUM_REQ-1:0] mask_s;
    logic [2:0]         winner_s;
    logic               any_s;
    logic [2:0]         ptr_next_s;
    logic [FW-1:0]      frames_s [8];

    // Eight slots so the 3-bit winner index always addresses a full array.
    for (genvar g = 0; g < 8; g++) begin : g_frames
        if (g < NUM_REQ) begin : g_used
            assign frames_s[g] = req_data[g*FW +: FW];
        end else begin : g_pad
            assign frames_s[g] = '0;
        end
    end

    assign mask_s     = req_vld & req_en;
    assign ptr_next_s = (winner_s == 3'(NUM_REQ - 1)) ? 3'd0 : winner_s + 3'd1;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req_mask (mask_s),
        .ptr      (ptr_r),
        .winner   (winner_s),
        .any      (any_s)
    );

    // Arbitration FSM with capture register, handshake outputs and frame counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            ptr_r       <= 3'd0;
            req_ack     <= '0;
            req_done    <= '0;
            ctl_tx_data <= '0;
            ctl_tx_vld  <= 1'b0;
            busy        <= 1'b0;
            grant_id    <= 3'd0;
            frame_cnt   <= 16'd0;
        end else begin
            req_ack  <= '0;
            req_done <= '0;
            case (state_r)
                ST_IDLE: begin
                    if (ctl_tx_rdy && any_s) begin
                        ctl_tx_data <= frames_s[winner_s];
                        grant_id    <= winner_s;
                        req_ack     <= ONE_HOT0 << winner_s;
                        ptr_r       <= ptr_next_s;
                        ctl_tx_vld  <= 1'b1;
                        busy        <= 1'b1;
                        state_r     <= ST_ISSUE;
                    end
                end
                // A high tx_rdy here is the controller not having seen vld yet.
                ST_ISSUE: begin
                    if (!ctl_tx_rdy) begin
                        ctl_tx_vld <= 1'b0;
                        state_r    <= ST_WAIT_DONE;
                    end
                end
                ST_WAIT_DONE: begin
                    if (ctl_tx_rdy) begin
                        req_done  <= ONE_HOT0 << grant_id;
                        frame_cnt <= frame_cnt + 16'd1;
                        busy      <= 1'b0;
                        state_r   <= ST_IDLE;
                    end
                end
                default: begin
                    ctl_tx_vld <= 1'b0;
                    busy       <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter against a behavioural controller whose
// tx_rdy drops after accepting a frame and returns 180 cycles later.
module tb_uart_tx_arbiter;

    localparam int N  = 4;
    localparam int FW = 144;

    logic            clk = 1'b0;
    logic            rst;
    logic [N-1:0]    req_en;
    logic [N-1:0]    req_vld;
    logic [N*FW-1:0] req_data;
    logic [N-1:0]    req_ack;
    logic [N-1:0]    req_done;
    logic [FW-1:0]   ctl_tx_data;
    logic            ctl_tx_vld;
    logic            ctl_tx_rdy;
    logic            busy;
    logic [2:0]      grant_id;
    logic [15:0]     frame_cnt;

    logic            rdy_m    = 1'b1;
    int              busy_cnt = 0;
    logic            hold_low = 1'b0;
    logic [FW-1:0]   frm [N];
    logic [FW-1:0]   alt_frame;
    int              n_pass  = 0;
    int              n_total = 0;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .NUM_REQ            (N),
        .TX_DATA_BYTE_WIDTH (18)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req_en      (req_en),
        .req_vld     (req_vld),
        .req_data    (req_data),
        .req_ack     (req_ack),
        .req_done    (req_done),
        .ctl_tx_data (ctl_tx_data),
        .ctl_tx_vld  (ctl_tx_vld),
        .ctl_tx_rdy  (ctl_tx_rdy),
        .busy        (busy),
        .grant_id    (grant_id),
        .frame_cnt   (frame_cnt)
    );

    // Controller model: 18 bytes at 10 cycles each once a frame is accepted.
    always @(posedge clk) begin
        if (busy_cnt != 0) begin
            busy_cnt <= busy_cnt - 1;
            if (busy_cnt == 1) rdy_m <= 1'b1;
        end else if (rdy_m && ctl_tx_vld) begin
            rdy_m    <= 1'b0;
            busy_cnt <= 180;
        end
    end

    assign ctl_tx_rdy = rdy_m & ~hold_low;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic load_frames();
        for (int i = 0; i < N; i++) req_data[i*FW +: FW] = frm[i];
    endtask

    task automatic wait_ack(input logic [N-1:0] exp, input string tag);
        int n;
        int dones;
        n = 0;
        dones = 0;
        while (req_ack == '0 && n < 400) begin
            step();
            n++;
            if (req_done != '0) dones++;
        end
        chk({tag, "_ack"}, req_ack, exp);
        chk({tag, "_no_done_before_ack"}, dones, 0);
    endtask

    task automatic wait_done(input logic [N-1:0] exp, input string tag);
        int n;
        int acks;
        n = 0;
        acks = 0;
        while (req_done == '0 && n < 400) begin
            step();
            n++;
            if (req_ack != '0) acks++;
        end
        chk({tag, "_done"}, req_done, exp);
        chk({tag, "_no_ack_before_done"}, acks, 0);
    endtask

    task automatic run_frame(input int idx, input string tag);
        wait_ack(N'(1) << idx, tag);
        chk({tag, "_grant_id"}, grant_id, idx);
        chk({tag, "_data"}, ctl_tx_data, frm[idx]);
        wait_done(N'(1) << idx, tag);
    endtask

    initial begin
        frm[0] = 144'h0000_1111_2222_3333_4444_5555_6666_7777_8888;
        frm[1] = 144'hA1A1_B2B2_C3C3_D4D4_E5E5_F6F6_0707_1818_2929;
        frm[2] = 144'h0102_0304_0506_0708_090A_0B0C_0D0E_0F10_1112;
        frm[3] = 144'hDEAD_BEEF_CAFE_F00D_1234_5678_9ABC_DEF0_5A5A;
        alt_frame = 144'h7777_6666_5555_4444_3333_2222_1111_0000_FFFF;
        rst = 1'b1;
        req_en = 4'hF;
        req_vld = 4'h0;
        load_frames();
        step();
        step();
        chk("rst_ack", req_ack, 4'h0);
        chk("rst_vld", ctl_tx_vld, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_data", ctl_tx_data, 144'h0);
        chk("rst_cnt", frame_cnt, 16'd0);
        rst = 1'b0;

        // Single request from requester 2.
        req_vld = 4'b0100;
        step();
        chk("single_ack", req_ack, 4'b0100);
        chk("single_vld1", ctl_tx_vld, 1'b1);
        chk("single_busy", busy, 1'b1);
        chk("single_gid", grant_id, 3'd2);
        chk("single_data", ctl_tx_data, frm[2]);
        req_vld = 4'b0000;
        step();
        chk("single_vld2", ctl_tx_vld, 1'b1);
        chk("single_ack_pulse", req_ack, 4'b0000);
        step();
        chk("single_vld3", ctl_tx_vld, 1'b0);
        for (int n = 0; n < 400 && !ctl_tx_rdy; n++) step();
        chk("single_rdy_back", ctl_tx_rdy, 1'b1);
        chk("single_done_early", req_done, 4'b0000);
        step();
        chk("single_done", req_done, 4'b0100);
        chk("single_cnt", frame_cnt, 16'd1);
        chk("single_busy_end", busy, 1'b0);
        step();
        chk("single_done_pulse", req_done, 4'b0000);

        // All four requesters held valid from ptr 0.
        rst = 1'b1;
        step();
        rst = 1'b0;
        req_vld = 4'hF;
        run_frame(0, "rr0");
        run_frame(1, "rr1");
        run_frame(2, "rr2");
        run_frame(3, "rr3");
        run_frame(0, "rr4");
        rst = 1'b1;
        chk("rr_cnt", frame_cnt, 16'd5);
        step();

        // Requester 2 disabled.
        rst = 1'b0;
        req_en = 4'b1011;
        run_frame(0, "en0");
        run_frame(1, "en1");
        run_frame(3, "en3");
        run_frame(0, "en4");
        chk("en_cnt", frame_cnt, 16'd4);
        req_en = 4'hF;

        // Controller held busy: no grant until tx_rdy returns.
        req_vld = 4'b0010;
        hold_low = 1'b1;
        begin
            int acks;
            acks = 0;
            for (int n = 0; n < 20; n++) begin
                step();
                if (req_ack != '0) acks++;
            end
            chk("hold_no_ack", acks, 0);
        end
        hold_low = 1'b0;
        step();
        chk("hold_ack", req_ack, 4'b0010);
        req_vld = 4'b0000;
        wait_done(4'b0010, "hold");

        // Reset while in WAIT_DONE (ptr is 2 here).
        req_vld = 4'b0100;
        wait_ack(4'b0100, "rstw");
        req_vld = 4'b0000;
        step();
        step();
        step();
        chk("rstw_busy", busy, 1'b1);
        chk("rstw_vld", ctl_tx_vld, 1'b0);
        rst = 1'b1;
        step();
        chk("rstw_done", req_done, 4'b0000);
        chk("rstw_busy0", busy, 1'b0);
        chk("rstw_data", ctl_tx_data, 144'h0);
        chk("rstw_gid", grant_id, 3'd0);
        chk("rstw_cnt", frame_cnt, 16'd0);
        rst = 1'b0;
        req_vld = 4'hF;
        wait_ack(4'b0001, "post_rst");
        chk("post_rst_data", ctl_tx_data, frm[0]);
        wait_done(4'b0001, "post_rst");
        chk("post_rst_cnt", frame_cnt, 16'd1);

        // Data change after ack does not disturb the frame in flight.
        req_vld = 4'b0001;
        wait_ack(4'b0001, "hold_data");
        step();
        req_data[0 +: FW] = alt_frame;
        step();
        chk("hold_data_mid", ctl_tx_data, frm[0]);
        wait_done(4'b0001, "hold_data");
        chk("hold_data_end", ctl_tx_data, frm[0]);
        wait_ack(4'b0001, "new_data");
        chk("new_data", ctl_tx_data, alt_frame);
        req_vld = 4'b0000;
        wait_done(4'b0001, "new_data");
        chk("final_cnt", frame_cnt, 16'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
